// File: rtl/pe_mem_arbiter.sv
// rtl/pe_mem_arbiter.sv - round-robin arbiter sharing one memory read port among PEs
module pe_mem_arbiter #(
   parameter int NUM_PE  = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   localparam int ID_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_PE-1:0]        req_i,
   input  logic [NUM_PE*ADDR_W-1:0] addr_i,
   output logic [NUM_PE-1:0]        ack_o,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     mem_req_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   input  logic                     mem_ack_i,
   input  logic [DATA_W-1:0]        mem_rdata_i,
   output logic                     busy_o,
   output logic [ID_W-1:0]          grant_id_o,
   output logic                     timeout_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   // Last watchdog count value before the abort fires; only meaningful when TIMEOUT != 0.
   localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t              state;
   logic [ID_W-1:0]     ptr;
   logic [CNT_W-1:0]    wd_cnt;
   logic                mask_vld;

   logic [NUM_PE-1:0]   req_eff;
   logic [ID_W:0]       cand;
   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [ADDR_W-1:0]   win_addr;
   logic [ID_W-1:0]     ptr_next;
   logic                wd_expire;

   // Pick the first requester at or after ptr, ignoring the PE just served for one cycle.
   always_comb begin
      req_eff = req_i;
      if (mask_vld) begin
         req_eff[grant_id_o] = 1'b0;
      end
      cand      = '0;
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         cand = {1'b0, ptr} + (ID_W + 1)'(i);
         if (cand >= (ID_W + 1)'(NUM_PE)) begin
            cand = cand - (ID_W + 1)'(NUM_PE);
         end
         if (!win_found && req_eff[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[ID_W-1:0];
         end
      end
      win_addr = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         if (ID_W'(k) == win_id) begin
            win_addr = addr_i[k*ADDR_W +: ADDR_W];
         end
      end
      ptr_next  = (win_id == ID_W'(NUM_PE - 1)) ? '0 : win_id + 1'b1;
      wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack_o      <= '0;
         rdata_o    <= '0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         busy_o     <= 1'b0;
         grant_id_o <= '0;
         timeout_o  <= 1'b0;
         ptr        <= '0;
         wd_cnt     <= '0;
         mask_vld   <= 1'b0;
      end else begin
         ack_o     <= '0;
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               mask_vld <= 1'b0;
               if (win_found) begin
                  grant_id_o <= win_id;
                  mem_addr_o <= win_addr;
                  mem_req_o  <= 1'b1;
                  busy_o     <= 1'b1;
                  wd_cnt     <= '0;
                  ptr        <= ptr_next;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (!mem_ack_i) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
               // An ack landing on the last watchdog cycle still wins over the abort.
               if (mem_ack_i) begin
                  rdata_o   <= mem_rdata_i;
                  mem_req_o <= 1'b0;
                  ack_o     <= NUM_PE'(1) << grant_id_o;
                  state     <= RESP;
               end else if (wd_expire) begin
                  rdata_o   <= '0;
                  mem_req_o <= 1'b0;
                  ack_o     <= NUM_PE'(1) << grant_id_o;
                  timeout_o <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               rdata_o  <= '0;
               busy_o   <= 1'b0;
               mask_vld <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// tb/tb_pe_mem_arbiter.sv - scoreboard bench for pe_mem_arbiter
module tb_pe_mem_arbiter;

   localparam int NPE = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NPE-1:0]    req;
   logic [NPE*AW-1:0] addr;
   logic [NPE-1:0]    ack;
   logic [DW-1:0]     rdata;
   logic              mem_req;
   logic [AW-1:0]     mem_addr;
   logic              mem_ack;
   logic [DW-1:0]     mem_rdata;
   logic              busy;
   logic [1:0]        grant_id;
   logic              timeout;

   pe_mem_arbiter #(.NUM_PE(NPE), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .ack_o(ack), .rdata_o(rdata),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .grant_id_o(grant_id), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            pe;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            to;
      int            resp;
   } txn_t;

   txn_t exp_q[$];
   txn_t mt;
   int   ack_log[$];
   int   ack_cyc_log[$];

   int n_checks = 0;
   int n_errors = 0;

   // reference model: one access at a time, described by its grant cycle and window ends
   bit            m_active;
   int            m_idle_at, m_ptr, m_mask, m_g, m_req_end, m_resp, m_ack_cyc;
   logic [DW-1:0] m_data;

   // PE-side behaviour and scenario knobs
   bit            pe_req[NPE];
   logic [AW-1:0] pe_addr[NPE];
   bit            pe_fly[NPE];
   int            pe_drop[NPE];
   bit            want[NPE];
   bit            want_once[NPE];
   logic [AW-1:0] want_addr[NPE];
   bit            rnd_mode, fix_data, do_rst, late_ack;
   int            p_new, mem_delay;
   logic [DW-1:0] fix_val;
   bit            exp_req = 1'b0;
   bit            exp_busy = 1'b0;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   // monitor: per-cycle bus expectations and scoreboard pop on every ack pulse
   always @(negedge clk) begin
      logic [NPE-1:0] oh;
      int idx;
      if (mon_en) begin
         chk("mem_req", 64'(mem_req), 64'(exp_req));
         chk("busy", 64'(busy), 64'(exp_busy));
         if (ack != '0) begin
            idx = 0;
            for (int p = 0; p < NPE; p++) if (ack[p]) idx = p;
            ack_log.push_back(idx);
            ack_cyc_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_ack: got ack 0x%0h with no access outstanding at cycle %0d", ack, cyc);
            end else begin
               mt = exp_q.pop_front();
               oh = '0;
               oh[mt.pe] = 1'b1;
               chk("ack_onehot", 64'(ack), 64'(oh));
               chk("grant_id", 64'(grant_id), 64'(mt.pe));
               chk("rdata", 64'(rdata), 64'(mt.d));
               chk("timeout_flag", 64'(timeout), 64'(mt.to));
               chk("mem_addr", 64'(mem_addr), 64'(mt.a));
               chk("ack_cycle", 64'(cyc), 64'(mt.resp));
            end
         end else begin
            chk("timeout_without_ack", 64'(timeout), 64'd0);
         end
      end
   end

   task automatic step();
      int c, win, j;
      logic [NPE-1:0] mreq;
      txn_t nt;
      c = cyc;
      exp_req  = m_active && (c > m_g) && (c <= m_req_end);
      exp_busy = m_active && (c > m_g) && (c <= m_resp);
      reset = 1'b0;
      for (int p = 0; p < NPE; p++) begin
         if (pe_fly[p]) begin
            if (c == pe_drop[p]) begin
               pe_req[p] = 1'b0;
               pe_fly[p] = 1'b0;
            end else if (rnd_mode && $urandom_range(0, 9) < 3) begin
               pe_addr[p] = $urandom;
            end
         end else if (pe_req[p]) begin
            if (rnd_mode && $urandom_range(0, 19) == 0) pe_req[p] = 1'b0;
         end else if (want[p]) begin
            pe_req[p]  = 1'b1;
            pe_addr[p] = want_addr[p];
            if (want_once[p]) want[p] = 1'b0;
         end else if (rnd_mode && $urandom_range(0, 99) < p_new) begin
            pe_req[p]  = 1'b1;
            pe_addr[p] = $urandom;
         end
         req[p] = pe_req[p];
         addr[p*AW +: AW] = pe_addr[p];
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (do_rst) begin
         do_rst    = 1'b0;
         reset     = 1'b1;
         late_ack  = 1'b1;
         m_active  = 1'b0;
         m_idle_at = c + 1;
         m_ptr     = 0;
         m_mask    = -1;
         m_ack_cyc = -1;
         exp_q.delete();
         for (int p = 0; p < NPE; p++) pe_fly[p] = 1'b0;
      end else begin
         if (m_active && c == m_ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = m_data;
         end else if (late_ack) begin
            mem_ack  = 1'b1;
            late_ack = 1'b0;
         end else if (rnd_mode && !(m_active && c > m_g && c <= m_req_end) && $urandom_range(0, 9) == 0) begin
            mem_ack = 1'b1;
         end
         if (c >= m_idle_at) begin
            mreq = req;
            if (c == m_idle_at && m_mask >= 0) mreq[m_mask] = 1'b0;
            win = -1;
            for (int i = 0; i < NPE; i++) begin
               if (win < 0 && mreq[(m_ptr + i) % NPE]) win = (m_ptr + i) % NPE;
            end
            if (win >= 0) begin
               j = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, TO + 2));
               m_active = 1'b1;
               m_g      = c;
               m_data   = fix_data ? fix_val : $urandom;
               if (j < TO) begin
                  m_ack_cyc = c + 1 + j;
                  m_req_end = c + 1 + j;
                  m_resp    = c + 2 + j;
               end else begin
                  m_ack_cyc = -1;
                  m_req_end = c + TO;
                  m_resp    = c + 1 + TO;
               end
               m_idle_at    = m_resp + 1;
               m_mask       = win;
               m_ptr        = (win + 1) % NPE;
               pe_fly[win]  = 1'b1;
               pe_drop[win] = m_resp + 2;
               nt.pe   = win;
               nt.a    = pe_addr[win];
               nt.d    = (j < TO) ? m_data : '0;
               nt.to   = (j >= TO);
               nt.resp = m_resp;
               exp_q.push_back(nt);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mon_en    = 1'b0;
      reset     = 1'b1;
      req       = '0;
      addr      = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      m_active  = 1'b0;
      m_idle_at = cyc;
      m_ptr     = 0;
      m_mask    = -1;
      m_g       = -10;
      m_ack_cyc = -1;
      exp_q.delete();
      for (int p = 0; p < NPE; p++) begin
         pe_req[p]  = 1'b0;
         pe_fly[p]  = 1'b0;
         pe_addr[p] = '0;
      end
      exp_req  = 1'b0;
      exp_busy = 1'b0;
      mon_en   = 1'b1;
   endtask

   task automatic drain();
      int n;
      bit pending;
      n = 0;
      pending = 1'b1;
      while (pending && n < 400) begin
         step();
         n++;
         pending = (cyc < m_idle_at) || (exp_q.size() != 0);
         for (int p = 0; p < NPE; p++) if (pe_req[p] || want[p]) pending = 1'b1;
      end
      n_checks++;
      if (pending) begin
         n_errors++;
         $display("FAIL drain: activity still pending after %0d cycles", n);
      end
   endtask

   task automatic request_once(input int p, input logic [AW-1:0] a);
      want_addr[p] = a;
      want_once[p] = 1'b1;
      want[p]      = 1'b1;
   endtask

   initial begin
      int n0;
      rnd_mode  = 1'b0;
      fix_data  = 1'b0;
      do_rst    = 1'b0;
      late_ack  = 1'b0;
      p_new     = 0;
      mem_delay = 0;
      fix_val   = '0;
      for (int p = 0; p < NPE; p++) begin
         want[p]      = 1'b0;
         want_once[p] = 1'b0;
         want_addr[p] = '0;
      end

      do_reset();
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);

      // single request from PE2, ack three cycles into the access
      mem_delay = 3;
      fix_data  = 1'b1;
      fix_val   = 32'hDEADBEEF;
      request_once(2, 32'h100);
      drain();
      fix_data  = 1'b0;

      // round-robin fairness with every PE requesting and immediate acks
      do_reset();
      ack_log.delete();
      ack_cyc_log.delete();
      mem_delay = 0;
      for (int p = 0; p < NPE; p++) begin
         want_addr[p] = 32'h1000 + 32'(p * 4);
         want_once[p] = 1'b0;
         want[p]      = 1'b1;
      end
      repeat (30) step();
      for (int p = 0; p < NPE; p++) want[p] = 1'b0;
      drain();
      chk("rr_count", 64'(ack_log.size() >= 8), 64'd1);
      if (ack_log.size() >= 8) begin
         for (int i = 0; i < 8; i++) chk("rr_order", 64'(ack_log[i]), 64'(i % 4));
         for (int i = 1; i < 8; i++) chk("rr_spacing", 64'(ack_cyc_log[i] - ack_cyc_log[i-1]), 64'd3);
      end

      // re-grant mask: lone PE1 must get exactly one access
      n0 = ack_log.size();
      request_once(1, 32'h2222_0000);
      drain();
      chk("mask_single_access", 64'(ack_log.size() - n0), 64'd1);

      // watchdog abort on PE3
      mem_delay = TO + 5;
      request_once(3, 32'h3333_0030);
      drain();

      // ack on the last watchdog cycle wins
      mem_delay = TO - 1;
      fix_data  = 1'b1;
      fix_val   = 32'hC0FFEE01;
      request_once(0, 32'h0000_0ACE);
      drain();
      fix_data  = 1'b0;

      // reset while in REQ, then PE0 must win the next arbitration
      mem_delay = 40;
      request_once(2, 32'h4444_0040);
      step();
      request_once(0, 32'h5555_0050);
      request_once(3, 32'h6666_0060);
      step();
      step();
      do_rst = 1'b1;
      step();
      mem_delay = 1;
      n0 = ack_log.size();
      drain();
      chk("post_reset_count", 64'(ack_log.size() - n0), 64'd3);
      if (ack_log.size() > n0) chk("post_reset_first", 64'(ack_log[n0]), 64'd0);

      // randomized traffic with withdrawals, address churn, spurious acks and timeouts
      rnd_mode  = 1'b1;
      mem_delay = -1;
      p_new     = 25;
      repeat (2000) step();
      rnd_mode  = 1'b0;
      drain();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
